// File: rtl/inst_encode_fifo.sv
// Micro-op to RV32I instruction encoder feeding a DEPTH-entry valid/ready FIFO.
// Each entry holds the encoded word plus an encode-error bit.
// Optional macro INST_ENC_RANGE_CHECK_EN: also flag immediates that the target
// format cannot represent (the truncated word is still pushed).
module inst_encode_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [5:0]                   in_op_type,
  input  logic [4:0]                   in_rd,
  input  logic [4:0]                   in_rs1,
  input  logic [4:0]                   in_rs2,
  input  logic [31:0]                  in_imm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_inst,
  output logic                         out_err,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

`ifdef INST_ENC_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  // Micro-op codes shared with the decoder
  localparam logic [5:0] OP_NOP  = 6'd0,  OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL  = 6'd3;
  localparam logic [5:0] OP_JALR = 6'd4,  OP_BEQ  = 6'd5,  OP_BNE   = 6'd6,  OP_BLT  = 6'd7;
  localparam logic [5:0] OP_BGE  = 6'd8,  OP_BLTU = 6'd9,  OP_BGEU  = 6'd10, OP_LB   = 6'd11;
  localparam logic [5:0] OP_LH   = 6'd12, OP_LW   = 6'd13, OP_LBU   = 6'd14, OP_LHU  = 6'd15;
  localparam logic [5:0] OP_SB   = 6'd16, OP_SH   = 6'd17, OP_SW    = 6'd18, OP_ADDI = 6'd19;
  localparam logic [5:0] OP_SLTI = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22, OP_ORI  = 6'd23;
  localparam logic [5:0] OP_ANDI = 6'd24, OP_SLLI = 6'd25, OP_SRLI  = 6'd26, OP_SRAI = 6'd27;
  localparam logic [5:0] OP_ADD  = 6'd28, OP_SUB  = 6'd29, OP_SLL   = 6'd30, OP_SLT  = 6'd31;
  localparam logic [5:0] OP_SLTU = 6'd32, OP_XOR  = 6'd33, OP_SRL   = 6'd34, OP_SRA  = 6'd35;
  localparam logic [5:0] OP_OR   = 6'd36, OP_AND  = 6'd37;

  // Instruction formats
  localparam logic [2:0] FMT_NONE = 3'd0, FMT_U = 3'd1, FMT_J = 3'd2, FMT_I = 3'd3;
  localparam logic [2:0] FMT_SH   = 3'd4, FMT_R = 3'd5, FMT_S = 3'd6, FMT_B = 3'd7;

  logic [2:0]  fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        unknown;
  logic [31:0] enc_inst;
  logic        enc_err;
  logic        i_bad, b_bad, j_bad, u_bad, sh_bad;

  // Classify the micro-op: format, major opcode and function fields
  always_comb begin
    fmt     = FMT_NONE;
    opc     = 7'b0010011;
    f3      = 3'b000;
    f7      = 7'b0000000;
    unknown = 1'b0;
    case (in_op_type)
      OP_NOP:   fmt = FMT_NONE;
      OP_LUI:   begin fmt = FMT_U; opc = 7'b0110111; end
      OP_AUIPC: begin fmt = FMT_U; opc = 7'b0010111; end
      OP_JAL:   begin fmt = FMT_J; opc = 7'b1101111; end
      OP_JALR:  begin fmt = FMT_I; opc = 7'b1100111; end
      OP_BEQ:   begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b000; end
      OP_BNE:   begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b001; end
      OP_BLT:   begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b100; end
      OP_BGE:   begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b101; end
      OP_BLTU:  begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b110; end
      OP_BGEU:  begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b111; end
      OP_LB:    begin fmt = FMT_I; opc = 7'b0000011; f3 = 3'b000; end
      OP_LH:    begin fmt = FMT_I; opc = 7'b0000011; f3 = 3'b001; end
      OP_LW:    begin fmt = FMT_I; opc = 7'b0000011; f3 = 3'b010; end
      OP_LBU:   begin fmt = FMT_I; opc = 7'b0000011; f3 = 3'b100; end
      OP_LHU:   begin fmt = FMT_I; opc = 7'b0000011; f3 = 3'b101; end
      OP_SB:    begin fmt = FMT_S; opc = 7'b0100011; f3 = 3'b000; end
      OP_SH:    begin fmt = FMT_S; opc = 7'b0100011; f3 = 3'b001; end
      OP_SW:    begin fmt = FMT_S; opc = 7'b0100011; f3 = 3'b010; end
      OP_ADDI:  begin fmt = FMT_I; f3 = 3'b000; end
      OP_SLTI:  begin fmt = FMT_I; f3 = 3'b010; end
      OP_SLTIU: begin fmt = FMT_I; f3 = 3'b011; end
      OP_XORI:  begin fmt = FMT_I; f3 = 3'b100; end
      OP_ORI:   begin fmt = FMT_I; f3 = 3'b110; end
      OP_ANDI:  begin fmt = FMT_I; f3 = 3'b111; end
      OP_SLLI:  begin fmt = FMT_SH; f3 = 3'b001; end
      OP_SRLI:  begin fmt = FMT_SH; f3 = 3'b101; end
      OP_SRAI:  begin fmt = FMT_SH; f3 = 3'b101; f7 = 7'b0100000; end
      OP_ADD:   begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b000; end
      OP_SUB:   begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000; end
      OP_SLL:   begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b001; end
      OP_SLT:   begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b010; end
      OP_SLTU:  begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b011; end
      OP_XOR:   begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b100; end
      OP_SRL:   begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b101; end
      OP_SRA:   begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b101; f7 = 7'b0100000; end
      OP_OR:    begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b110; end
      OP_AND:   begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b111; end
      default:  unknown = 1'b1;
    endcase
  end

  // Immediate representability for each format (upper bits must be a sign extension)
  assign i_bad  = !((&in_imm[31:11]) || !(|in_imm[31:11]));
  assign b_bad  = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
  assign j_bad  = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
  assign u_bad  = |in_imm[11:0];
  assign sh_bad = (in_imm[11:5] != f7);

  // Pack fields into the instruction word and derive the error bit
  always_comb begin
    enc_inst = NOP_INST;
    enc_err  = unknown;
    case (fmt)
      FMT_U: begin
        enc_inst = {in_imm[31:12], in_rd, opc};
        enc_err  = RANGE_CHECK && u_bad;
      end
      FMT_J: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
        enc_err  = RANGE_CHECK && j_bad;
      end
      FMT_I: begin
        enc_inst = {in_imm[11:0], in_rs1, f3, in_rd, opc};
        enc_err  = RANGE_CHECK && i_bad;
      end
      FMT_SH: begin
        enc_inst = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
        enc_err  = RANGE_CHECK && sh_bad;
      end
      FMT_R: enc_inst = {f7, in_rs2, in_rs1, f3, in_rd, opc};
      FMT_S: begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
        enc_err  = RANGE_CHECK && i_bad;
      end
      FMT_B: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
        enc_err  = RANGE_CHECK && b_bad;
      end
      default: ;
    endcase
  end

  // FIFO storage and control
  logic [32:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_inst  = out_valid ? mem[rd_ptr][31:0] : NOP_INST;
  assign out_err   = out_valid && mem[rd_ptr][32];

  // Pointer and occupancy update; flush beats push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry write; contents only matter while counted as occupied
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {enc_err, enc_inst};
  end

endmodule

// File: tb/tb_inst_encode_fifo.sv
// Self-checking bench for inst_encode_fifo: directed cases followed by random
// traffic, compared against a queue-based reference model.
// Honours INST_ENC_RANGE_CHECK_EN the same way the design does.
module tb_inst_encode_fifo;

  localparam int DEPTH = 4;

  localparam logic [5:0] OP_NOP = 6'd0, OP_LUI = 6'd1, OP_AUIPC = 6'd2, OP_JAL = 6'd3;
  localparam logic [5:0] OP_JALR = 6'd4, OP_BEQ = 6'd5, OP_SW = 6'd18, OP_ADDI = 6'd19;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [5:0]  in_op_type;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_inst;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] q[$];

  inst_encode_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op_type(in_op_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder: field placement by bit position, ranges by signed arithmetic
  function automatic logic [32:0] ref_encode(input logic [5:0] op, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [31:0] imm);
    logic [31:0] w;
    logic        e;
    int          v;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  alu_f3 [6];
    logic [2:0]  ld_f3 [5];
    logic [2:0]  br_f3 [6];
    logic [2:0]  r_f3 [10];
    alu_f3 = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    ld_f3  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    br_f3  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    r_f3   = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    v = $signed(imm);
    w = 32'h0000_0013;
    e = 1'b0;
    if (op == 0) begin
      // NOP
    end else if (op == 1 || op == 2) begin
      w = 32'h0;
      w[31:12] = imm[31:12];
      w[11:7] = rd;
      w[6:0] = (op == 1) ? 7'h37 : 7'h17;
      e = (imm % 4096) != 0;
    end else if (op == 3) begin
      w = 32'h0;
      w[31] = imm[20];
      w[30:21] = imm[10:1];
      w[20] = imm[11];
      w[19:12] = imm[19:12];
      w[11:7] = rd;
      w[6:0] = 7'h6F;
      e = v < -(1 << 20) || v >= (1 << 20) || imm[0];
    end else if (op == 4 || (op >= 11 && op <= 15) || (op >= 19 && op <= 24)) begin
      if (op == 4) begin
        f3 = 3'd0;
      end else if (op <= 15) begin
        f3 = ld_f3[op - 11];
      end else begin
        f3 = alu_f3[op - 19];
      end
      w = 32'h0;
      w[31:20] = imm[11:0];
      w[19:15] = rs1;
      w[14:12] = f3;
      w[11:7] = rd;
      w[6:0] = (op == 4) ? 7'h67 : (op <= 15) ? 7'h03 : 7'h13;
      e = v < -2048 || v > 2047;
    end else if (op >= 5 && op <= 10) begin
      w = 32'h0;
      w[31] = imm[12];
      w[30:25] = imm[10:5];
      w[24:20] = rs2;
      w[19:15] = rs1;
      w[14:12] = br_f3[op - 5];
      w[11:8] = imm[4:1];
      w[7] = imm[11];
      w[6:0] = 7'h63;
      e = v < -4096 || v > 4095 || imm[0];
    end else if (op >= 16 && op <= 18) begin
      w = 32'h0;
      w[31:25] = imm[11:5];
      w[24:20] = rs2;
      w[19:15] = rs1;
      w[14:12] = 3'(op - 16);
      w[11:7] = imm[4:0];
      w[6:0] = 7'h23;
      e = v < -2048 || v > 2047;
    end else if (op >= 25 && op <= 27) begin
      f7 = (op == 27) ? 7'h20 : 7'h00;
      w = 32'h0;
      w[31:25] = f7;
      w[24:20] = imm[4:0];
      w[19:15] = rs1;
      w[14:12] = (op == 25) ? 3'd1 : 3'd5;
      w[11:7] = rd;
      w[6:0] = 7'h13;
      e = imm[11:5] != f7;
    end else if (op >= 28 && op <= 37) begin
      w = 32'h0;
      w[31:25] = (op == 29 || op == 35) ? 7'h20 : 7'h00;
      w[24:20] = rs2;
      w[19:15] = rs1;
      w[14:12] = r_f3[op - 28];
      w[11:7] = rd;
      w[6:0] = 7'h33;
    end else begin
      return {1'b1, 32'h0000_0013};
    end
`ifndef INST_ENC_RANGE_CHECK_EN
    e = 1'b0;
`endif
    return {e, w};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [32:0] head;
    head = (q.size() != 0) ? q[0] : {1'b0, 32'h0000_0013};
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    chk("count", 32'(count), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_inst", out_inst, head[31:0]);
    chk("out_err", 32'(out_err), 32'(head[32]));
  endtask

  // One clock: predict from inputs, advance the model, check after the edge
  task automatic tick();
    bit push, pop;
    logic [32:0] item;
    push = in_valid && (q.size() != DEPTH) && !flush;
    pop  = out_ready && (q.size() != 0) && !flush;
    item = ref_encode(in_op_type, in_rd, in_rs1, in_rs2, in_imm);
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(item);
    end
    check_all();
  endtask

  task automatic set_in(input logic v, input logic [5:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    in_valid = v;
    in_op_type = op;
    in_rd = rd;
    in_rs1 = rs1;
    in_rs2 = rs2;
    in_imm = imm;
  endtask

  // Push one micro-op into an empty FIFO, check the head literally, then drain it
  task automatic directed(input string tag, input logic [5:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [31:0] exp_inst, input logic exp_err);
    set_in(1'b1, op, rd, rs1, rs2, imm);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_inst"}, out_inst, exp_inst);
    chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [5:0] op;
    logic [31:0] imm;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 32'd0);
    #2;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    directed("addi", OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    directed("lui", OP_LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    directed("beq", OP_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
    directed("sw", OP_SW, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0);
`ifdef INST_ENC_RANGE_CHECK_EN
    directed("addi800", OP_ADDI, 5'd1, 5'd0, 5'd0, 32'h800, 32'h8000_0093, 1'b1);
`else
    directed("addi800", OP_ADDI, 5'd1, 5'd0, 5'd0, 32'h800, 32'h8000_0093, 1'b0);
`endif
    directed("unknown", 6'h3F, 5'd1, 5'd2, 5'd3, 32'h1234, 32'h0000_0013, 1'b1);

    // Fill to full with the consumer stalled; the fifth push must be refused
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, OP_ADDI, 5'(i + 1), 5'd0, 5'd0, 32'(i + 10));
      tick();
      if (i == 3) begin
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'd4);
      end
    end
    out_ready = 1'b1;
    tick();
    chk("pop_when_full", 32'(count), 32'd3);
    tick();
    chk("push_after_pop", 32'(count), 32'd3);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, OP_JAL, 5'd1, 5'd0, 5'd0, 32'(8 * (i + 1)));
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_inst", out_inst, 32'h0000_0013);
    rst_n = 1'b1;
    tick();

    // Flush wins over a simultaneous push
    set_in(1'b1, OP_AUIPC, 5'd3, 5'd0, 5'd0, 32'h0000_1000);
    tick();
    tick();
    flush = 1'b1;
    tick();
    chk("flush_count", 32'(count), 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(38, 63)) : 6'($urandom_range(0, 37));
      case ($urandom_range(0, 3))
        0: imm = 32'($signed($urandom_range(0, 4095)) - 2048);
        1: imm = 32'($urandom_range(0, 31)) | (($urandom_range(0, 1) == 1) ? 32'h400 : 32'h0);
        2: imm = $urandom() & 32'hFFFF_F000;
        default: imm = $urandom();
      endcase
      set_in($urandom_range(0, 2) != 0, op, 5'($urandom()), 5'($urandom()), 5'($urandom()), imm);
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 31) == 0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
